// File: rtl/irda_mir_encoder.sv
`default_nettype none
// ============================================================================
// irda_mir_encoder : MIR quarter-bit pulse encoder with 5-ones zero insertion
// Revision: 1.0
// ============================================================================
module irda_mir_encoder #(
  parameter int PULSE_PHASE = 0
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic fast_enable,
  input  logic mir_mode,
  input  logic tx_select,
  input  logic bit_i,
  input  logic stuff_en_i,
  input  logic bit_valid_i,
  output logic bit_ready_o,
  output logic tx_o,
  output logic busy_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] PHASE = PULSE_PHASE[1:0];

  state_t     state, state_nx;
  logic [1:0] q, q_nx;
  logic       cur, cur_nx;
  logic       cur_stuff, cur_stuff_nx;
  logic [2:0] ones, ones_nx, ones_done;
  logic       hold_bit, hold_bit_nx;
  logic       hold_stuff, hold_stuff_nx;
  logic       hold_valid, hold_valid_nx;
  logic       tx, tx_nx;
  logic       enabled;
  logic       tick;

  always_comb begin
    enabled       = mir_mode & tx_select;
    tick          = enabled & fast_enable;
    state_nx      = state;
    q_nx          = q;
    cur_nx        = cur;
    cur_stuff_nx  = cur_stuff;
    ones_nx       = ones;
    hold_bit_nx   = hold_bit;
    hold_stuff_nx = hold_stuff;
    hold_valid_nx = hold_valid;
    tx_nx         = tx;
    // Ones run length as it stands once the current bit has been sent.
    ones_done     = (cur && cur_stuff) ? ones + 3'd1 : 3'd0;

    if (!enabled) begin
      state_nx      = IDLE;
      q_nx          = 2'd0;
      tx_nx         = 1'b0;
      hold_valid_nx = 1'b0;
      ones_nx       = 3'd0;
    end else begin
      // Accept needs an empty holder and consume needs a full one, so the two never collide.
      if (bit_valid_i && !hold_valid) begin
        hold_bit_nx   = bit_i;
        hold_stuff_nx = stuff_en_i;
        hold_valid_nx = 1'b1;
      end
      if (tick) begin
        case (state)
          IDLE: begin
            tx_nx = 1'b0;
            q_nx  = 2'd0;
            if (hold_valid) begin
              cur_nx        = hold_bit;
              cur_stuff_nx  = hold_stuff;
              hold_valid_nx = 1'b0;
              state_nx      = SEND;
            end
          end
          SEND: begin
            tx_nx = ~cur && (q == PHASE);
            q_nx  = q + 2'd1;
            if (q == 2'd3) begin
              ones_nx = ones_done;
              if (ones_done == 3'd5) begin
                // Inserted zero: never counted, holder left for the bit after it.
                cur_nx       = 1'b0;
                cur_stuff_nx = 1'b0;
              end else if (hold_valid) begin
                cur_nx        = hold_bit;
                cur_stuff_nx  = hold_stuff;
                hold_valid_nx = 1'b0;
              end else begin
                state_nx = IDLE;
                q_nx     = 2'd0;
              end
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      q          <= 2'd0;
      cur        <= 1'b1;
      cur_stuff  <= 1'b0;
      ones       <= 3'd0;
      hold_bit   <= 1'b0;
      hold_stuff <= 1'b0;
      hold_valid <= 1'b0;
      tx         <= 1'b0;
    end else begin
      state      <= state_nx;
      q          <= q_nx;
      cur        <= cur_nx;
      cur_stuff  <= cur_stuff_nx;
      ones       <= ones_nx;
      hold_bit   <= hold_bit_nx;
      hold_stuff <= hold_stuff_nx;
      hold_valid <= hold_valid_nx;
      tx         <= tx_nx;
    end
  end

  assign bit_ready_o = ~hold_valid;
  assign busy_o      = (state == SEND);
  assign tx_o        = tx;

endmodule
`default_nettype wire

// File: tb/tb_irda_mir_encoder.sv
`default_nettype none
// ============================================================================
// tb_irda_mir_encoder : randomized bench against a slot-queue encoding model
// Revision: 1.0
// ============================================================================
module tb_irda_mir_encoder;

  localparam int PP = 0;

  logic clk = 1'b0;
  logic wb_rst_i, fast_enable, mir_mode, tx_select;
  logic bit_i, stuff_en_i, bit_valid_i;
  logic bit_ready_o, tx_o, busy_o;

  always #5 clk = ~clk;

  irda_mir_encoder #(.PULSE_PHASE(PP)) dut (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .fast_enable (fast_enable),
    .mir_mode    (mir_mode),
    .tx_select   (tx_select),
    .bit_i       (bit_i),
    .stuff_en_i  (stuff_en_i),
    .bit_valid_i (bit_valid_i),
    .bit_ready_o (bit_ready_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: bits waiting to be handed over, and the expected
  // tx level for every quarter-bit slot of the stuffed bit stream.
  logic drv_bit[$];
  logic drv_stf[$];
  logic slots[$];
  bit   armed, loaded, frame_open;
  int   m_ones;
  int   slots_done;
  int   tick_mode;
  int   clk_cnt;
  logic exp_tx;

  task automatic add_coded_bit(input logic b);
    for (int k = 0; k < 4; k++) slots.push_back(!b && (k == PP));
  endtask

  task automatic drive_inputs();
    bit_valid_i = (drv_bit.size() > 0);
    if (drv_bit.size() > 0) begin
      bit_i      = drv_bit[0];
      stuff_en_i = drv_stf[0];
    end else begin
      bit_i      = 1'($urandom_range(0, 1));
      stuff_en_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_frame(input logic [31:0] bits, input logic [31:0] stf, input int n);
    frame_open = 0;
    slots_done = 0;
    for (int i = 0; i < n; i++) begin
      drv_bit.push_back(bits[i]);
      drv_stf.push_back(stf[i]);
      add_coded_bit(bits[i]);
      if (bits[i] && stf[i]) m_ones++;
      else m_ones = 0;
      if (m_ones == 5) begin
        add_coded_bit(1'b0);
        m_ones = 0;
      end
    end
    drive_inputs();
  endtask

  task automatic step();
    bit   acc, tk, en;
    logic dummy;
    en  = mir_mode && tx_select;
    acc = bit_valid_i && bit_ready_o && en;
    tk  = en && fast_enable;
    @(posedge clk);
    #1;
    if (!en) begin
      slots.delete();
      drv_bit.delete();
      drv_stf.delete();
      loaded = 0;
      armed  = 0;
      m_ones = 0;
      exp_tx = 1'b0;
    end else begin
      if (tk) begin
        if (loaded) begin
          exp_tx = slots.pop_front();
          slots_done++;
          if (slots.size() == 0) loaded = 0;
        end else begin
          exp_tx = 1'b0;
          if (armed) begin
            loaded = 1;
            armed  = 0;
          end
        end
      end
      if (acc) begin
        dummy = drv_bit.pop_front();
        dummy = drv_stf.pop_front();
        if (!frame_open) begin
          frame_open = 1;
          armed      = 1;
        end
      end
    end
    check("tx", tx_o, exp_tx);
    check("busy", busy_o, loaded);
    clk_cnt++;
    case (tick_mode)
      0:       fast_enable = 1'b1;
      1:       fast_enable = (clk_cnt % 4 == 0);
      default: fast_enable = 1'($urandom_range(0, 1));
    endcase
    drive_inputs();
  endtask

  task automatic run_frame(input logic [31:0] bits, input logic [31:0] stf, input int n);
    int guard;
    start_frame(bits, stf, n);
    guard = 0;
    while (!(frame_open && !armed && !loaded && drv_bit.size() == 0) && guard < 3000) begin
      step();
      guard++;
    end
    if (guard >= 3000) check("frame_timeout", 32'd1, 32'd0);
    repeat (3) step();
  endtask

  task automatic model_clear();
    slots.delete();
    drv_bit.delete();
    drv_stf.delete();
    loaded = 0;
    armed  = 0;
    m_ones = 0;
    exp_tx = 1'b0;
  endtask

  initial begin
    int guard;
    wb_rst_i    = 1'b1;
    fast_enable = 1'b0;
    mir_mode    = 1'b1;
    tx_select   = 1'b1;
    bit_i       = 1'b0;
    stuff_en_i  = 1'b0;
    bit_valid_i = 1'b0;
    tick_mode   = 0;
    clk_cnt     = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ready", bit_ready_o, 1'b1);
    wb_rst_i    = 1'b0;
    fast_enable = 1'b1;

    // Single zero, then 1,1,0 with stuffing, six ones, and a flag byte.
    run_frame(32'h0, 32'h1, 1);
    run_frame(32'h3, 32'h7, 3);
    run_frame(32'h3F, 32'h3F, 6);
    run_frame(32'h7E, 32'h0, 8);

    // One tick per four clocks.
    tick_mode = 1;
    run_frame(32'h3, 32'h7, 3);
    run_frame(32'h7E, 32'h0, 8);
    run_frame(32'h3F, 32'h3F, 6);

    // Abort by dropping tx_select two slots into the first bit.
    tick_mode = 0;
    start_frame(32'hE, 32'hF, 4);
    guard = 0;
    while (slots_done < 2 && guard < 200) begin
      step();
      guard++;
    end
    check("abort_reach", (slots_done == 2), 1'b1);
    tx_select = 1'b0;
    step();
    check("abort_ready", bit_ready_o, 1'b1);
    tx_select = 1'b1;
    run_frame(32'h1E, 32'h1F, 6);

    // Asynchronous reset in the middle of a frame.
    start_frame(32'h3F, 32'h3F, 6);
    guard = 0;
    while (slots_done < 5 && guard < 200) begin
      step();
      guard++;
    end
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("arst_tx", tx_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_ready", bit_ready_o, 1'b1);
    model_clear();
    bit_valid_i = 1'b0;
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    run_frame(32'h2, 32'h3, 3);

    // Randomized frames and tick patterns.
    for (int f = 0; f < 14; f++) begin
      tick_mode = (f < 4) ? 2 : $urandom_range(0, 2);
      run_frame($urandom | $urandom, $urandom | $urandom, $urandom_range(1, 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irda_mir_encoder.md
IRDA_MIR_ENCODER -- requirements
Module: irda_mir_encoder

Interface
REQ-001 Parameter PULSE_PHASE, default 0: quarter-bit slot (0-3) in which a 0 bit drives its pulse.
REQ-002 clk  input  1  system clock.
REQ-003 wb_rst_i  input  1  reset; asynchronous, active-high; clock clk.
REQ-004 fast_enable  input  1  one-cycle tick at 4x MIR bit rate; each tick is one quarter-bit slot.
REQ-005 mir_mode  input  1  MIR mode selected.
REQ-006 tx_select  input  1  transmit direction selected.
REQ-007 bit_i  input  1  next data bit from framer.
REQ-008 stuff_en_i  input  1  bit_i participates in zero insertion (0 for flag bytes).
REQ-009 bit_valid_i  input  1  bit_i/stuff_en_i valid.
REQ-010 bit_ready_o  output  1  holding register empty; can accept a bit.
REQ-011 tx_o  output  1  IR pulse output, registered.
REQ-012 busy_o  output  1  encoder is in SEND state.

Function
REQ-013 Enabled = mir_mode && tx_select; tick = enabled && fast_enable.
REQ-014 One-entry holding register {bit, stuff_en, valid}; bit_ready_o = ~valid.
REQ-015 Accept on any clk with bit_valid_i && bit_ready_o && enabled; ticks are not required for acceptance.
REQ-016 A bit consumed from the holding register on the same edge as a new accept SHALL NOT occur: ready is deasserted while valid, so no simultaneous accept and consume.
REQ-017 States IDLE, SEND; 2-bit phase counter q; current-bit register cur; 3-bit ones counter.
REQ-018 IDLE: tx_o=0, q=0; on tick with holding valid -> load cur from holding, clear holding valid, go SEND; tx_o stays 0 on that tick.
REQ-019 SEND, each tick: tx_o <= (~cur && q==PULSE_PHASE); q <= q+1 (wraps 3->0).
REQ-020 On a SEND tick with q==3, the bit completes; update ones counter: cur==1 with stuff flag set -> ones+1, otherwise -> 0.
REQ-021 Next-bit selection at q==3 tick, in priority order: (a) updated ones==5 -> cur<=0 as stuffed bit, stuff flag 0, holding untouched; (b) holding valid -> load and consume; (c) -> go IDLE, q=0.
REQ-022 Stuffed bit resets ones counter to 0 when it completes; it is never counted.
REQ-023 Ticks outside SEND do not change q or ones counter.
REQ-024 fast_enable low: all state frozen, tx_o holds its value.
REQ-025 enabled dropping to 0 on any clk: synchronous abort -> IDLE, q=0, tx_o=0, holding valid=0, ones=0; any bit in flight is lost.
REQ-026 busy_o = (state==SEND); bit_ready_o and busy_o are combinational from registers only.
REQ-027 One data bit occupies exactly 4 ticks on tx_o; a 0 produces exactly one tick-wide high, a 1 produces none.

Reset
REQ-028 While wb_rst_i=1: state IDLE, q=0, cur=1, ones=0, holding valid=0, tx_o=0, busy_o=0, bit_ready_o=1.
REQ-029 Reset mid-SEND takes effect immediately, independent of clk; after release, the first accepted bit restarts at q=0.

Verification
REQ-030 Tick every clk, PULSE_PHASE=0, feed bit 0 -> tx_o high exactly on the 2nd tick after accept (quarter 0 of bit), low for the next 3 ticks, then busy_o falls.
REQ-031 Stream 1,1,0 back-to-back, stuff_en=1 -> tx_o low for 8 ticks, then 1 high, 3 low; bit_ready_o re-asserts once per 4 ticks.
REQ-032 Six 1s with stuff_en=1 -> after the 5th 1, a stuffed 0 pulse appears; the 6th 1 follows; total 28 ticks in SEND.
REQ-033 0x7E flag (0,1x6,0) with stuff_en=0 -> no insertion; exactly 2 pulses in 32 ticks.
REQ-034 fast_enable tick every 4 clks -> identical tx_o sequence stretched 4x; tx_o constant between ticks.
REQ-035 tx_select deasserted in mid-bit at q=2 -> next clk tx_o=0, busy_o=0, bit_ready_o=1; a new frame starts cleanly at q=0.
